// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between EX and the iterative HI/LO multiply unit.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic             op_sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_en;
    logic             wr_hi;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic             rd_hi;
    logic             op_ready;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op_sign, a, b, wr_en, wr_hi, wr_data, rd_req, rd_hi,
        input  op_ready, busy, stall, done, rd_data, hi, lo
    );

    modport slave (
        input  op_valid, op_sign, a, b, wr_en, wr_hi, wr_data, rd_req, rd_hi,
        output op_ready, busy, stall, done, rd_data, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add HI/LO multiplier with MFHI/MFLO/MTHI/MTLO service and pipeline stall.
// Signed operands are multiplied as magnitudes and the product is negated in the FIX cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;
    logic             neg, neg_nxt;
    logic             done, done_nxt;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    result;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            mplier <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            mplier <= mplier_nxt;
            mcand  <= mcand_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            neg    <= neg_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        mplier_nxt = mplier;
        mcand_nxt  = mcand;
        hi_nxt     = hi;
        lo_nxt     = lo;
        neg_nxt    = neg;
        done_nxt   = 1'b0;

        sum    = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
        prod   = {acc, mplier};
        result = neg ? (~prod + PW'(1)) : prod;
        // Magnitude of the most negative value is itself read as unsigned
        a_mag  = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag  = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

        case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    if (bus.op_sign) begin
                        mcand_nxt  = a_mag;
                        mplier_nxt = b_mag;
                        neg_nxt    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_nxt  = bus.a;
                        mplier_nxt = bus.b;
                        neg_nxt    = 1'b0;
                    end
                end else if (bus.wr_en) begin
                    if (bus.wr_hi) begin
                        hi_nxt = bus.wr_data;
                    end else begin
                        lo_nxt = bus.wr_data;
                    end
                end
            end
            RUN: begin
                acc_nxt    = sum[WIDTH:1];
                mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                hi_nxt    = result[PW-1:WIDTH];
                lo_nxt    = result[WIDTH-1:0];
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.op_ready = (state == IDLE);
    assign bus.stall    = (state != IDLE) & (bus.op_valid | bus.wr_en | bus.rd_req);
    assign bus.done     = done;
    assign bus.hi       = hi;
    assign bus.lo       = lo;
    assign bus.rd_data  = bus.rd_hi ? hi : lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: directed corner cases plus random traffic against a cycle-level behavioural model.
module tb_muldiv_sequencer;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();
    muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: busy countdown, pending product, architectural HI/LO
    int           m_left = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    bit           m_done = 1'b0;

    function automatic logic [63:0] ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = 64'(x);
        uy = 64'(y);
        return ux * uy;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lit(input string name, input logic [W-1:0] act, input logic [W-1:0] mdl,
                           input logic [W-1:0] exp);
        chk(name, 64'(act), 64'(exp));
        chk({name, "_model"}, 64'(mdl), 64'(exp));
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else if (bus.op_valid) begin
                {p_hi, p_lo} = ref_mul(bus.op_sign, bus.a, bus.b);
                m_left = W + 1;
            end else if (bus.wr_en) begin
                if (bus.wr_hi) m_hi = bus.wr_data;
                else           m_lo = bus.wr_data;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (reset) begin
            chk("busy",     64'(bus.busy),     64'(m_left > 0));
            chk("op_ready", 64'(bus.op_ready), 64'(m_left == 0));
            chk("stall",    64'(bus.stall),
                64'((m_left > 0) && (bus.op_valid || bus.wr_en || bus.rd_req)));
            chk("done",     64'(bus.done),     64'(m_done));
            chk("hi",       64'(bus.hi),       64'(m_hi));
            chk("lo",       64'(bus.lo),       64'(m_lo));
            chk("rd_data",  64'(bus.rd_data),  64'(bus.rd_hi ? m_hi : m_lo));
        end
    end

    task automatic clear_in();
        bus.op_valid = 1'b0;
        bus.op_sign  = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.wr_en    = 1'b0;
        bus.wr_hi    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_hi    = 1'b0;
    endtask

    // Hold the request until an edge at which the unit was idle
    task automatic issue_op(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, output int waits);
        logic rdy;
        rdy = 1'b0;
        waits = 0;
        bus.op_valid = 1'b1;
        bus.op_sign  = s;
        bus.a        = x;
        bus.b        = y;
        for (int i = 0; i < 200; i++) begin
            rdy = bus.op_ready;
            @(posedge clk);
            #1;
            waits++;
            if (rdy) break;
        end
        chk("op_accept", 64'(rdy), 64'd1);
        bus.op_valid = 1'b0;
    endtask

    task automatic issue_write(input bit h, input logic [W-1:0] d);
        logic rdy;
        rdy = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_hi   = h;
        bus.wr_data = d;
        for (int i = 0; i < 200; i++) begin
            rdy = bus.op_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        chk("wr_accept", 64'(rdy), 64'd1);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_done(output int n, output int stalls);
        n = 0;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
            if (bus.stall) stalls++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, s, dcnt;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi",       64'(bus.hi),       64'd0);
        chk("rst_lo",       64'(bus.lo),       64'd0);
        chk("rst_busy",     64'(bus.busy),     64'd0);
        chk("rst_done",     64'(bus.done),     64'd0);
        chk("rst_op_ready", 64'(bus.op_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned all-ones square, latency and single-cycle done
        issue_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        wait_done(n, s);
        chk("t1_latency", 64'(n), 64'(W + 1));
        chk_lit("t1_hi", bus.hi, m_hi, 32'hFFFF_FFFE);
        chk_lit("t1_lo", bus.lo, m_lo, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", 64'(bus.done), 64'd0);

        // Signed corners
        issue_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, w);
        wait_done(n, s);
        chk_lit("t2a_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        chk_lit("t2a_lo", bus.lo, m_lo, 32'hFFFF_FFFF);
        issue_op(1'b1, 32'h8000_0000, 32'h8000_0000, w);
        wait_done(n, s);
        chk_lit("t2b_hi", bus.hi, m_hi, 32'h4000_0000);
        chk_lit("t2b_lo", bus.lo, m_lo, 32'h0000_0000);

        // 7 * -3 with MFLO held through the busy window
        issue_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, w);
        bus.rd_req = 1'b1;
        bus.rd_hi  = 1'b0;
        wait_done(n, s);
        chk("t3_stall_cycles", 64'(s), 64'(W));
        chk("t3_stall_done", 64'(bus.stall), 64'd0);
        chk_lit("t3_rd_data", bus.rd_data, m_lo, 32'hFFFF_FFEB);
        chk_lit("t3_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        bus.rd_req = 1'b0;

        // MTLO in idle, then MTHI held across a run
        issue_write(1'b0, 32'h1234_5678);
        chk_lit("t4_lo", bus.lo, m_lo, 32'h1234_5678);
        chk_lit("t4_hi", bus.hi, m_hi, 32'hFFFF_FFFF);
        issue_op(1'b0, 32'd3, 32'd4, w);
        issue_write(1'b1, 32'hCAFE_F00D);
        chk_lit("t4_mthi_hi", bus.hi, m_hi, 32'hCAFE_F00D);
        chk_lit("t4_mthi_lo", bus.lo, m_lo, 32'd12);

        // Back-to-back acceptance in the done cycle
        issue_op(1'b0, 32'd10, 32'd10, w);
        wait_done(n, s);
        chk("t5_first_done", 64'(bus.done), 64'd1);
        issue_op(1'b0, 32'd2, 32'd3, w);
        chk("t5_no_gap", 64'(w), 64'd1);
        wait_done(n, s);
        chk("t5_latency", 64'(n), 64'(W + 1));
        chk_lit("t5_lo", bus.lo, m_lo, 32'd6);
        chk_lit("t5_hi", bus.hi, m_hi, 32'd0);

        // Reset in the middle of a run
        issue_op(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, w);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_busy",     64'(bus.busy),     64'd0);
        chk("t6_op_ready", 64'(bus.op_ready), 64'd1);
        chk("t6_hi",       64'(bus.hi),       64'd0);
        chk("t6_lo",       64'(bus.lo),       64'd0);
        chk("t6_done",     64'(bus.done),     64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dcnt++;
        end
        chk("t6_no_done", 64'(dcnt), 64'd0);
        issue_op(1'b0, 32'd5, 32'd5, w);
        wait_done(n, s);
        chk_lit("t6_lo", bus.lo, m_lo, 32'd25);
        chk_lit("t6_hi", bus.hi, m_hi, 32'd0);

        // Random traffic; the per-cycle compare does the checking
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    issue_op(1'($urandom_range(0, 1)), pick(), pick(), w);
                    if ($urandom_range(0, 2) == 0) begin
                        issue_write(1'($urandom_range(0, 1)), $urandom);
                    end else begin
                        bus.rd_req = 1'($urandom_range(0, 1));
                        bus.rd_hi  = 1'($urandom_range(0, 1));
                        wait_done(n, s);
                        bus.rd_req = 1'b0;
                    end
                end
                2: issue_write(1'($urandom_range(0, 1)), $urandom);
                default: begin
                    bus.rd_req = 1'($urandom_range(0, 1));
                    bus.rd_hi  = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    bus.rd_req = 1'b0;
                end
            endcase
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
